hdcpu_datapath: RTL and testbench

//  Datapath and beat sequencer that consumes the hardwired controller's control word and returns IR[7:4], W[3:1], C, Z.

---
 rtl/hdcpu_pkg.sv | 31 +++
 rtl/hdcpu_alu.sv | 53 +++++
 rtl/hdcpu_datapath.sv | 158 +++++++++++++++
 tb/tb_hdcpu_datapath.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdcpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hdcpu_pkg : shared widths, ALU S-codes and beat encodings for hdcpu       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package hdcpu_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 8;

  // Arithmetic codes (M=0)
  localparam logic [3:0] ADD   = 4'b1001;
  localparam logic [3:0] SUB   = 4'b0110;
  localparam logic [3:0] INC   = 4'b0000;
  localparam logic [3:0] DEC   = 4'b1111;
  // Logic codes (M=1)
  localparam logic [3:0] AND   = 4'b1011;
  localparam logic [3:0] PASSB = 4'b1010;
  localparam logic [3:0] XOR   = 4'b0110;
  localparam logic [3:0] OR    = 4'b1110;
  localparam logic [3:0] PASSA = 4'b1111;
  localparam logic [3:0] NOTA  = 4'b0000;

  typedef enum logic [2:0] {
    W1 = 3'b001,
    W2 = 3'b010,
    W3 = 3'b100
  } beat_t;

endpackage
`default_nettype wire

// File: rtl/hdcpu_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hdcpu_alu : combinational 74181-subset ALU, CIN is active-low carry-in    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module hdcpu_alu
  import hdcpu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [3:0]    S,
  input  logic          M,
  input  logic          CIN,
  output logic [DW-1:0] F,
  output logic          cout
);

  logic [DW:0] w_cin;
  logic [DW:0] w_sum;

  assign w_cin = {{DW{1'b0}}, ~CIN};

  always_comb begin
    w_sum = '0;
    F     = '0;
    cout  = 1'b0;
    if (!M) begin
      case (S)
        ADD:     w_sum = {1'b0, A} + {1'b0, B} + w_cin;
        SUB:     w_sum = {1'b0, A} + {1'b0, ~B} + w_cin;
        INC:     w_sum = {1'b0, A} + w_cin;
        DEC:     w_sum = {1'b0, A} + {1'b0, {DW{1'b1}}} + w_cin;
        default: w_sum = '0;
      endcase
      F    = w_sum[DW-1:0];
      cout = w_sum[DW];
    end else begin
      case (S)
        AND:     F = A & B;
        PASSB:   F = B;
        XOR:     F = A ^ B;
        OR:      F = A | B;
        PASSA:   F = A;
        NOTA:    F = ~A;
        default: F = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/hdcpu_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hdcpu_datapath : regfile, ALU, PC/AR/IR, flags, memory, W1-W3 sequencer   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module hdcpu_datapath
  import hdcpu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          QD,
  input  logic [DW-1:0] SWD,
  input  logic          LDC,
  input  logic          LDZ,
  input  logic          CIN,
  input  logic          M,
  input  logic          ABUS,
  input  logic          DRW,
  input  logic          PCINC,
  input  logic          LPC,
  input  logic          LAR,
  input  logic          PCADD,
  input  logic          ARINC,
  input  logic          SELCTL,
  input  logic          MEMW,
  input  logic          STOP,
  input  logic          LIR,
  input  logic          SBUS,
  input  logic          MBUS,
  input  logic          SHORT,
  input  logic          LONG,
  input  logic [3:0]    S,
  input  logic [3:0]    SEL,
  output logic [7:0]    IR,
  output logic [2:0]    W,
  output logic          C,
  output logic          Z,
  output logic          T3,
  output logic [AW-1:0] PC,
  output logic [AW-1:0] AR,
  output logic [DW-1:0] BUS,
  output logic          BUS_ERR
);

  beat_t         r_beat;
  beat_t         w_beat_nxt;
  logic          r_running;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_ar;
  logic [7:0]    r_ir;
  logic [DW-1:0] r_reg [4];
  logic [DW-1:0] r_mem [2**AW];
  logic          r_c;
  logic          r_z;
  logic          r_bus_err;

  logic [1:0]    w_a_sel;
  logic [1:0]    w_b_sel;
  logic [DW-1:0] w_f;
  logic          w_cout;
  logic [DW-1:0] w_bus;
  logic          w_multi;
  logic [AW-1:0] w_off;

  assign w_a_sel = SELCTL ? SEL[3:2] : r_ir[3:2];
  assign w_b_sel = SELCTL ? SEL[1:0] : r_ir[1:0];

  hdcpu_alu #(.DW(DW)) u_alu (
    .A    (r_reg[w_a_sel]),
    .B    (r_reg[w_b_sel]),
    .S    (S),
    .M    (M),
    .CIN  (CIN),
    .F    (w_f),
    .cout (w_cout)
  );

  always_comb begin
    w_bus = '0;
    if (MBUS)      w_bus = r_mem[r_ar];
    else if (ABUS) w_bus = w_f;
    else if (SBUS) w_bus = SWD;
  end

  assign w_multi = (MBUS & ABUS) | (MBUS & SBUS) | (ABUS & SBUS);
  assign w_off   = {{(AW-4){r_ir[3]}}, r_ir[3:0]};

  // Beat sequencer: W only moves on executing edges
  always_comb begin
    w_beat_nxt = r_beat;
    if (r_running) begin
      case (r_beat)
        W1:      w_beat_nxt = SHORT ? W1 : W2;
        W2:      w_beat_nxt = LONG ? W3 : W1;
        default: w_beat_nxt = W1;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_beat    <= W1;
      r_running <= 1'b0;
    end else begin
      r_beat <= w_beat_nxt;
      if (r_running) begin
        if (STOP) r_running <= 1'b0;
      end else if (QD) begin
        r_running <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_pc      <= '0;
      r_ar      <= '0;
      r_ir      <= '0;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
      r_bus_err <= 1'b0;
      for (int i = 0; i < 4; i++) r_reg[i] <= '0;
    end else if (r_running) begin
      if (DRW)     r_reg[w_a_sel] <= w_bus;
      if (LIR)     r_ir <= r_mem[r_pc][7:0];
      if (LDC)     r_c <= w_cout;
      if (LDZ)     r_z <= (w_f == '0);
      if (w_multi) r_bus_err <= 1'b1;

      if (LAR)        r_ar <= w_bus[AW-1:0];
      else if (ARINC) r_ar <= r_ar + 1'b1;

      if (LPC)        r_pc <= w_bus[AW-1:0];
      else if (PCADD) r_pc <= r_pc + w_off;
      else if (PCINC) r_pc <= r_pc + 1'b1;
    end
  end

  // Memory contents survive CLR
  always_ff @(posedge CLK) begin
    if (r_running && MEMW) r_mem[r_ar] <= w_bus;
  end

  assign IR      = r_ir;
  assign W       = r_beat;
  assign C       = r_c;
  assign Z       = r_z;
  assign T3      = r_running;
  assign PC      = r_pc;
  assign AR      = r_ar;
  assign BUS     = w_bus;
  assign BUS_ERR = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_hdcpu_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hdcpu_datapath : directed vectors for hdcpu_datapath                  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_hdcpu_datapath;
  import hdcpu_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          CLR, QD;
  logic [DW-1:0] SWD;
  logic          LDC, LDZ, CIN, M, ABUS, DRW, PCINC, LPC, LAR, PCADD, ARINC;
  logic          SELCTL, MEMW, STOP, LIR, SBUS, MBUS, SHORT, LONG;
  logic [3:0]    S, SEL;
  logic [7:0]    IR;
  logic [2:0]    W;
  logic          C, Z, T3, BUS_ERR;
  logic [AW-1:0] PC, AR;
  logic [DW-1:0] BUS;

  int n_vec = 0;
  int n_mis = 0;

  hdcpu_datapath #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .CLR(CLR), .QD(QD), .SWD(SWD),
    .LDC(LDC), .LDZ(LDZ), .CIN(CIN), .M(M), .ABUS(ABUS), .DRW(DRW),
    .PCINC(PCINC), .LPC(LPC), .LAR(LAR), .PCADD(PCADD), .ARINC(ARINC),
    .SELCTL(SELCTL), .MEMW(MEMW), .STOP(STOP), .LIR(LIR), .SBUS(SBUS),
    .MBUS(MBUS), .SHORT(SHORT), .LONG(LONG), .S(S), .SEL(SEL),
    .IR(IR), .W(W), .C(C), .Z(Z), .T3(T3), .PC(PC), .AR(AR),
    .BUS(BUS), .BUS_ERR(BUS_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_ctl();
    {LDC, LDZ, CIN, M, ABUS, DRW, PCINC, LPC, LAR, PCADD, ARINC} = '0;
    {SELCTL, MEMW, STOP, LIR, SBUS, MBUS, SHORT, LONG, QD} = '0;
    SWD = '0; S = '0; SEL = '0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start();
    QD = 1'b1;
    step();
    QD = 1'b0;
  endtask

  task automatic ldreg(input logic [1:0] idx, input logic [7:0] v);
    clr_ctl();
    SELCTL = 1'b1; SEL = {idx, 2'b00}; SBUS = 1'b1; SWD = v; DRW = 1'b1;
    step();
    clr_ctl();
  endtask

  task automatic rdreg(input logic [1:0] idx, input logic [7:0] exp, input string tag);
    @(negedge CLK);
    clr_ctl();
    SELCTL = 1'b1; SEL = {idx, 2'b00}; M = 1'b1; S = PASSA; ABUS = 1'b1;
    #1 chk(tag, 32'(BUS), 32'(exp));
    clr_ctl();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    CLR = 1'b0;
    #1;
    chk("rst_w", 32'(W), 32'h1);
    chk("rst_pc", 32'(PC), 32'h0);
    chk("rst_cz", 32'({C, Z}), 32'h0);
    chk("rst_t3", 32'(T3), 32'h0);
    chk("rst_err", 32'(BUS_ERR), 32'h0);
    #1 CLR = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    clr_ctl();
    CLR = 1'b0;
    repeat (2) @(negedge CLK);
    CLR = 1'b1;
    chk("init_w", 32'(W), 32'h1);
    chk("init_ar_ir", 32'({AR, IR}), 32'h0);
    chk("init_t3", 32'(T3), 32'h0);
    step();

    // Reset taken mid-W2, then halted until QD
    start();
    chk("run_t3", 32'(T3), 32'h1);
    PCINC = 1'b1;
    step();
    chk("w2_pc", 32'(PC), 32'h1);
    chk("w2_w", 32'(W), 32'h2);
    do_reset();
    repeat (3) step();
    chk("halt_pc", 32'(PC), 32'h0);
    chk("halt_w", 32'(W), 32'h1);
    start();
    chk("qd_t3", 32'(T3), 32'h1);
    chk("qd_pc", 32'(PC), 32'h0);
    step();
    chk("resume_pc", 32'(PC), 32'h1);
    clr_ctl();

    // ADD via IR-selected registers: 7F + 81 = 0x100
    ldreg(2'd1, 8'h7F);
    ldreg(2'd2, 8'h81);
    LAR = 1'b1; SBUS = 1'b1; SWD = 8'h01;
    step();
    clr_ctl(); SBUS = 1'b1; SWD = 8'h16; MEMW = 1'b1;
    step();
    clr_ctl(); LIR = 1'b1;
    step();
    chk("lir_ir", 32'(IR), 32'h16);
    clr_ctl(); S = ADD; CIN = 1'b1; ABUS = 1'b1; DRW = 1'b1; LDC = 1'b1; LDZ = 1'b1;
    step();
    clr_ctl();
    chk("add_cz", 32'({C, Z}), 32'h3);
    rdreg(2'd1, 8'h00, "add_r1");
    rdreg(2'd2, 8'h81, "add_r2");

    // SUB 5-7, INC FF, XOR
    ldreg(2'd1, 8'h05);
    ldreg(2'd2, 8'h07);
    SELCTL = 1'b1; SEL = 4'b0110; S = SUB; ABUS = 1'b1; DRW = 1'b1; LDC = 1'b1; LDZ = 1'b1;
    step();
    clr_ctl();
    chk("sub_cz", 32'({C, Z}), 32'h0);
    rdreg(2'd1, 8'hFE, "sub_r1");
    ldreg(2'd1, 8'hFF);
    SELCTL = 1'b1; SEL = 4'b0100; S = INC; ABUS = 1'b1; DRW = 1'b1; LDC = 1'b1; LDZ = 1'b1;
    step();
    clr_ctl();
    chk("inc_cz", 32'({C, Z}), 32'h3);
    rdreg(2'd1, 8'h00, "inc_r1");
    ldreg(2'd1, 8'h3C);
    ldreg(2'd2, 8'h0F);
    SELCTL = 1'b1; SEL = 4'b0110; M = 1'b1; S = XOR; ABUS = 1'b1; DRW = 1'b1; LDC = 1'b1; LDZ = 1'b1;
    step();
    clr_ctl();
    chk("xor_cz", 32'({C, Z}), 32'h0);
    rdreg(2'd1, 8'h33, "xor_r1");

    // Sequencer
    do_reset();
    start();
    SHORT = 1'b1;
    step();
    chk("short_w", 32'(W), 32'h1);
    clr_ctl();
    step();
    chk("w1_w2", 32'(W), 32'h2);
    LONG = 1'b1;
    step();
    chk("long_w3", 32'(W), 32'h4);
    clr_ctl();
    step();
    chk("w3_w1", 32'(W), 32'h1);
    step();
    STOP = 1'b1; PCINC = 1'b1;
    step();
    chk("stop_w", 32'(W), 32'h1);
    chk("stop_t3", 32'(T3), 32'h0);
    chk("stop_pc", 32'(PC), 32'h1);
    STOP = 1'b0;
    repeat (5) step();
    chk("frozen_pc", 32'(PC), 32'h1);
    chk("frozen_w", 32'(W), 32'h1);
    clr_ctl();
    start();
    chk("resume_t3", 32'(T3), 32'h1);

    // Memory / AR
    SBUS = 1'b1; SWD = 8'h20; LAR = 1'b1;
    step();
    chk("lar_ar", 32'(AR), 32'h20);
    clr_ctl(); SBUS = 1'b1; SWD = 8'hA5; MEMW = 1'b1; ARINC = 1'b1;
    step();
    chk("arinc_ar", 32'(AR), 32'h21);
    clr_ctl(); SBUS = 1'b1; SWD = 8'h30; LAR = 1'b1; ARINC = 1'b1;
    step();
    chk("lar_wins", 32'(AR), 32'h30);
    clr_ctl(); SBUS = 1'b1; SWD = 8'h20; LAR = 1'b1;
    step();
    @(negedge CLK);
    clr_ctl(); MBUS = 1'b1;
    #1 chk("mbus_rd", 32'(BUS), 32'hA5);
    clr_ctl();

    // PC paths
    LPC = 1'b1; SBUS = 1'b1; SWD = 8'h10;
    step();
    chk("lpc_pc", 32'(PC), 32'h10);
    clr_ctl(); LAR = 1'b1; SBUS = 1'b1; SWD = 8'h10;
    step();
    clr_ctl(); SBUS = 1'b1; SWD = 8'h0E; MEMW = 1'b1;
    step();
    clr_ctl(); LIR = 1'b1;
    step();
    chk("lir2_ir", 32'(IR), 32'h0E);
    clr_ctl(); PCADD = 1'b1;
    step();
    chk("pcadd_pc", 32'(PC), 32'h0E);
    clr_ctl(); LPC = 1'b1; SBUS = 1'b1; SWD = 8'hFF;
    step();
    clr_ctl(); PCINC = 1'b1;
    step();
    chk("pc_wrap", 32'(PC), 32'h00);
    clr_ctl(); LPC = 1'b1; SBUS = 1'b1; SWD = 8'h40; PCINC = 1'b1;
    step();
    chk("lpc_wins", 32'(PC), 32'h40);

    // Unlisted ALU code and bus contention
    ldreg(2'd1, 8'h3C);
    @(negedge CLK);
    clr_ctl(); SELCTL = 1'b1; SEL = 4'b0100; S = 4'b0101; ABUS = 1'b1;
    #1 chk("unlisted_f", 32'(BUS), 32'h0);
    chk("err_clean", 32'(BUS_ERR), 32'h0);
    @(negedge CLK);
    clr_ctl(); SELCTL = 1'b1; SEL = 4'b0100; M = 1'b1; S = PASSA; ABUS = 1'b1;
    SBUS = 1'b1; SWD = 8'h55;
    #1 chk("prio_bus", 32'(BUS), 32'h3C);
    step();
    clr_ctl();
    chk("err_set", 32'(BUS_ERR), 32'h1);
    step();
    chk("err_sticky", 32'(BUS_ERR), 32'h1);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
